mem_dbg_arbiter: RTL and testbench
==================================

// Module: mem_dbg_arbiter
// PURPOSE
//  Shares the single RAM port between the CPU datapath and a debug/loader master.
//  Normally passes CPU address/data/OE_M/WE_M straight through to RAM. On a debug
//  request it pauses the CPU at a step boundary, performs one RAM read or write for
//  the debug master, acks it, then returns the bus to the CPU or holds it paused.
// PARAMETERS
//  ADDR_WIDTH     16     address bus width
//  DATA_WIDTH     8      data bus width
//  MEM_DEPTH      32768  RAM words; debug addresses >= MEM_DEPTH are out of range
//  DRAIN_TIMEOUT  15     max cycles spent in DRAIN waiting for cpu_idle
// PORTS
//  clk        in   1           clock
//  reset      in   1           reset, asynchronous, active-high
//  cpu_addr   in   ADDR_WIDTH  CPU address bus
//  cpu_wdata  in   DATA_WIDTH  CPU write data
//  cpu_we     in   1           CPU write strobe (WE_M)
//  cpu_oe     in   1           CPU read strobe (OE_M)
//  cpu_rdata  out  DATA_WIDTH  read data to CPU; always equals mem_rdata
//  cpu_idle   in   1           control unit at step boundary (T0), no access in flight
//  cpu_pause  out  1           freezes CPU timer/decoder while high
//  dbg_req    in   1           1-cycle request pulse
//  dbg_we     in   1           1 = write, 0 = read; sampled with dbg_req
//  dbg_addr   in   ADDR_WIDTH  debug address; sampled with dbg_req
//  dbg_wdata  in   DATA_WIDTH  debug write data; sampled with dbg_req
//  dbg_hold   in   1           keep CPU paused after ack
//  dbg_busy   out  1           high when not in IDLE or HOLD
//  dbg_ack    out  1           1-cycle completion pulse
//  dbg_err    out  1           valid with dbg_ack: out of range or drain timeout
//  dbg_rdata  out  DATA_WIDTH  read result; holds until the next read completes
//  mem_addr   out  ADDR_WIDTH  RAM address
//  mem_wdata  out  DATA_WIDTH  RAM write data
//  mem_we     out  1           RAM write enable
//  mem_oe     out  1           RAM output enable
//  mem_rdata  in   DATA_WIDTH  RAM read data
// BEHAVIOUR
//  Reset: state=IDLE; cpu_pause, dbg_ack, dbg_err, dbg_busy=0; dbg_rdata=0;
//   capture regs and timeout counter=0. Reset mid-transaction drops the access
//   (no ack), releases cpu_pause and returns the bus to the CPU immediately.
//  FSM states: IDLE, DRAIN, ACCESS, RESP, HOLD.
//  IDLE: mem_* = cpu_* combinationally (zero latency), cpu_pause=0.
//   dbg_req=1 -> capture we/addr/wdata, clear counter -> DRAIN.
//  DRAIN: cpu_pause=1; bus still CPU-owned. cpu_idle=1 -> ACCESS.
//   Counter reaches DRAIN_TIMEOUT with cpu_idle=0 -> RESP with err=1, no RAM access.
//  ACCESS (one cycle): mem_addr/mem_wdata = captured values; CPU strobes blocked.
//   In range: mem_we=cap_we, mem_oe=!cap_we; a read loads dbg_rdata from mem_rdata
//   at the clock edge leaving ACCESS. Out of range (addr >= MEM_DEPTH): both
//   strobes 0, err=1, dbg_rdata unchanged. -> RESP.
//  RESP: dbg_ack=1, dbg_err=err for this one cycle; cpu_pause stays 1.
//   dbg_hold=1 -> HOLD; else -> IDLE (cpu_pause low in IDLE).
//  HOLD: cpu_pause=1, mem_we=mem_oe=0, mem_addr = captured address.
//   dbg_req=1 -> capture -> ACCESS (drain skipped). dbg_hold=0 with no req -> IDLE.
//   dbg_req and dbg_hold=0 in the same cycle: the request wins.
//  dbg_req while dbg_busy=1 is ignored; no queueing, no ack.
//  Latency (req sampled in cycle N): from IDLE, ack at N+3 when cpu_idle is
//   already high; from HOLD, ack at N+2.
//  CPU strobes during DRAIN still reach RAM; during ACCESS/RESP/HOLD they never do.
//  mem_we and mem_oe are never high in the same cycle.
// TESTING
//  1 IDLE passthrough: cpu_addr=0x0010,cpu_we=1,wdata=0x5A -> mem_we=1, same cycle, RAM[0x10]=0x5A.
//  2 Debug write, cpu_idle=1: req we=1 addr=0x0002 wd=0x25 -> pause N+1, mem_we N+2, ack N+3, RAM[2]=0x25.
//  3 Debug read in HOLD: RAM[0]=0x8F, req we=0 addr=0 -> ack N+2, dbg_rdata=0x8F, cpu_pause stays 1.
//  4 Out of range: req addr=0x8000 -> ack with err=1, no mem strobe, dbg_rdata unchanged.
//  5 cpu_idle stuck 0 -> ack+err after DRAIN_TIMEOUT cycles, pause released, cpu_we passthrough resumes.
//  6 reset asserted during DRAIN -> cpu_pause=0 immediately, no ack; a later req completes normally.

Source files
------------

// File: rtl/mem_dbg_arbiter.sv
// mem_dbg_arbiter: shares the single RAM port between the CPU datapath and a
// debug/loader master, pausing the CPU at a step boundary for each debug access.
module mem_dbg_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 32768,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_oe,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  cpu_idle,
    output logic                  cpu_pause,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic                  dbg_hold,
    output logic                  dbg_busy,
    output logic                  dbg_ack,
    output logic                  dbg_err,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                  CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ACCESS,
        S_RESP,
        S_HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    cap_we;
    logic                    cap_we_nxt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [ADDR_WIDTH-1:0]   cap_addr_nxt;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH-1:0]   cap_wdata_nxt;
    logic                    err_q;
    logic                    err_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [DATA_WIDTH-1:0]   rdata_nxt;
    logic                    in_range;

    assign cpu_rdata = mem_rdata;
    assign in_range  = ({1'b0, cap_addr} < DEPTH_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            dbg_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cap_we    <= cap_we_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_wdata <= cap_wdata_nxt;
            err_q     <= err_nxt;
            cnt       <= cnt_nxt;
            dbg_rdata <= rdata_nxt;
        end
    end

    // Bus ownership: CPU owns the RAM in IDLE and DRAIN; the captured debug
    // request owns it from ACCESS onwards. A CPU read+write collision favours the write.
    always_comb begin
        state_nxt     = state;
        cap_we_nxt    = cap_we;
        cap_addr_nxt  = cap_addr;
        cap_wdata_nxt = cap_wdata;
        err_nxt       = err_q;
        cnt_nxt       = cnt;
        rdata_nxt     = dbg_rdata;

        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_oe    = cpu_oe & ~cpu_we;
        cpu_pause = 1'b1;
        dbg_busy  = 1'b1;
        dbg_ack   = 1'b0;
        dbg_err   = 1'b0;

        case (state)
            S_IDLE: begin
                cpu_pause = 1'b0;
                dbg_busy  = 1'b0;
                if (dbg_req) begin
                    cap_we_nxt    = dbg_we;
                    cap_addr_nxt  = dbg_addr;
                    cap_wdata_nxt = dbg_wdata;
                    err_nxt       = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (cpu_idle) begin
                    state_nxt = S_ACCESS;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_ACCESS: begin
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_we    = in_range & cap_we;
                mem_oe    = in_range & ~cap_we;
                state_nxt = S_RESP;
                if (!in_range) begin
                    err_nxt = 1'b1;
                end else if (!cap_we) begin
                    rdata_nxt = mem_rdata;
                end
            end

            S_RESP: begin
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_we    = 1'b0;
                mem_oe    = 1'b0;
                dbg_ack   = 1'b1;
                dbg_err   = err_q;
                state_nxt = dbg_hold ? S_HOLD : S_IDLE;
            end

            S_HOLD: begin
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_we    = 1'b0;
                mem_oe    = 1'b0;
                dbg_busy  = 1'b0;
                if (dbg_req) begin
                    cap_we_nxt    = dbg_we;
                    cap_addr_nxt  = dbg_addr;
                    cap_wdata_nxt = dbg_wdata;
                    err_nxt       = 1'b0;
                    state_nxt     = S_ACCESS;
                end else if (!dbg_hold) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dbg_arbiter.sv
// tb_mem_dbg_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a cycle-stamped transaction model with its own RAM image.
module tb_mem_dbg_arbiter;

    localparam int AW            = 16;
    localparam int DW            = 8;
    localparam int MEM_DEPTH     = 32768;
    localparam int DRAIN_TIMEOUT = 15;

    localparam int PH_IDLE   = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_ACCESS = 2;
    localparam int PH_RESP   = 3;
    localparam int PH_HOLD   = 4;

    logic          clk;
    logic          reset     = 1'b1;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_we    = 1'b0;
    logic          cpu_oe    = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_idle  = 1'b0;
    logic          cpu_pause;
    logic          dbg_req   = 1'b0;
    logic          dbg_we    = 1'b0;
    logic [AW-1:0] dbg_addr  = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_hold  = 1'b0;
    logic          dbg_busy;
    logic          dbg_ack;
    logic          dbg_err;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:MEM_DEPTH-1];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one outstanding transaction described by cycle stamps
    bit            txn_on      = 1'b0;
    bit            held        = 1'b0;
    bit            t_we        = 1'b0;
    bit            t_err       = 1'b0;
    logic [AW-1:0] t_addr      = '0;
    logic [DW-1:0] t_wdata     = '0;
    logic [DW-1:0] rd_exp      = '0;
    int            cyc         = 0;
    int            drain_begin = 0;
    int            acc_at      = -1;

    mem_dbg_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (MEM_DEPTH),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_oe   (cpu_oe),
        .cpu_rdata(cpu_rdata),
        .cpu_idle (cpu_idle),
        .cpu_pause(cpu_pause),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_hold (dbg_hold),
        .dbg_busy (dbg_busy),
        .dbg_ack  (dbg_ack),
        .dbg_err  (dbg_err),
        .dbg_rdata(dbg_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[14:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit in_rng(input logic [AW-1:0] a);
        return int'(a) < MEM_DEPTH;
    endfunction

    function automatic int phase();
        if (!txn_on)      return held ? PH_HOLD : PH_IDLE;
        if (acc_at < 0)   return PH_DRAIN;
        if (cyc == acc_at) return PH_ACCESS;
        return PH_RESP;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dbg_req = 1'b0;
            #1;
        end
    endtask

    task automatic waitAck(input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = budget + 1;
        for (int k = 1; k <= budget; k++) begin
            if (!found) begin
                applyStimulus(1);
                if (dbg_ack === 1'b1) begin
                    found  = 1'b1;
                    cycles = k;
                end
            end
        end
    endtask

    // Advance the model one clock; RAM image follows whoever legally owns the bus
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_on      = 1'b0;
            held        = 1'b0;
            t_we        = 1'b0;
            t_err       = 1'b0;
            t_addr      = '0;
            t_wdata     = '0;
            rd_exp      = '0;
            cyc         = 0;
            drain_begin = 0;
            acc_at      = -1;
        end else begin
            case (phase())
                PH_IDLE: begin
                    if (cpu_we) ram[cpu_addr[14:0]] = cpu_wdata;
                    if (dbg_req) begin
                        t_we        = dbg_we;
                        t_addr      = dbg_addr;
                        t_wdata     = dbg_wdata;
                        txn_on      = 1'b1;
                        acc_at      = -1;
                        drain_begin = cyc + 1;
                    end
                end
                PH_DRAIN: begin
                    if (cpu_we) ram[cpu_addr[14:0]] = cpu_wdata;
                    if (cpu_idle) begin
                        acc_at = cyc + 1;
                        t_err  = !in_rng(t_addr);
                    end else if (cyc - drain_begin + 1 >= DRAIN_TIMEOUT) begin
                        acc_at = cyc;
                        t_err  = 1'b1;
                    end
                end
                PH_ACCESS: begin
                    if (in_rng(t_addr)) begin
                        if (t_we) ram[t_addr[14:0]] = t_wdata;
                        else      rd_exp = ram[t_addr[14:0]];
                    end
                end
                PH_RESP: begin
                    txn_on = 1'b0;
                    held   = dbg_hold;
                end
                default: begin
                    if (dbg_req) begin
                        t_we    = dbg_we;
                        t_addr  = dbg_addr;
                        t_wdata = dbg_wdata;
                        txn_on  = 1'b1;
                        acc_at  = cyc + 1;
                        t_err   = !in_rng(t_addr);
                    end else if (!dbg_hold) begin
                        held = 1'b0;
                    end
                end
            endcase
            cyc++;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        int            ph;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic          e_oe;
        ph = phase();
        if (ph == PH_IDLE || ph == PH_DRAIN) begin
            e_addr = cpu_addr;
            e_we   = cpu_we;
            e_oe   = cpu_oe & ~cpu_we;
            checkOutput("mem_wdata_cpu", 32'(mem_wdata), 32'(cpu_wdata));
        end else if (ph == PH_ACCESS) begin
            e_addr = t_addr;
            e_we   = in_rng(t_addr) & t_we;
            e_oe   = in_rng(t_addr) & ~t_we;
            checkOutput("mem_wdata_dbg", 32'(mem_wdata), 32'(t_wdata));
        end else begin
            e_addr = t_addr;
            e_we   = 1'b0;
            e_oe   = 1'b0;
        end
        checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
        checkOutput("mem_we", 32'(mem_we), 32'(e_we));
        checkOutput("mem_oe", 32'(mem_oe), 32'(e_oe));
        checkOutput("strobe_excl", 32'(mem_we & mem_oe), 32'(0));
        checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(ram[e_addr[14:0]]));
        checkOutput("cpu_pause", 32'(cpu_pause), 32'(ph != PH_IDLE));
        checkOutput("dbg_busy", 32'(dbg_busy), 32'(txn_on));
        checkOutput("dbg_ack", 32'(dbg_ack), 32'(ph == PH_RESP));
        checkOutput("dbg_err", 32'(dbg_err), 32'((ph == PH_RESP) & t_err));
        checkOutput("dbg_rdata", 32'(dbg_rdata), 32'(rd_exp));
    end

    initial begin
        int lat;
        int s;
        for (int i = 0; i < MEM_DEPTH; i++) ram[i] = '0;

        applyStimulus(2);
        checkOutput("rst_pause", 32'(cpu_pause), 32'(0));
        checkOutput("rst_busy", 32'(dbg_busy), 32'(0));
        checkOutput("rst_ack", 32'(dbg_ack), 32'(0));
        checkOutput("rst_rdata", 32'(dbg_rdata), 32'(0));
        reset = 1'b0;
        applyStimulus(1);

        $display("[TB] directed: IDLE passthrough");
        cpu_idle = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        #1;
        checkOutput("t1_mem_we", 32'(mem_we), 32'(1));
        checkOutput("t1_mem_addr", 32'(mem_addr), 32'h10);
        checkOutput("t1_mem_wdata", 32'(mem_wdata), 32'h5A);
        applyStimulus(1);
        cpu_we = 1'b0;

        $display("[TB] directed: debug write from IDLE");
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0002; dbg_wdata = 8'h25; dbg_hold = 1'b0;
        applyStimulus(1);
        checkOutput("t2_pause_n1", 32'(cpu_pause), 32'(1));
        applyStimulus(1);
        checkOutput("t2_mem_we_n2", 32'(mem_we), 32'(1));
        checkOutput("t2_mem_addr_n2", 32'(mem_addr), 32'h2);
        checkOutput("t2_mem_wdata_n2", 32'(mem_wdata), 32'h25);
        applyStimulus(1);
        checkOutput("t2_ack_n3", 32'(dbg_ack), 32'(1));
        checkOutput("t2_err_n3", 32'(dbg_err), 32'(0));
        applyStimulus(1);

        $display("[TB] directed: debug reads while held");
        cpu_addr = 16'h0000; cpu_wdata = 8'h8F; cpu_we = 1'b1;
        applyStimulus(1);
        cpu_we = 1'b0;
        dbg_hold = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0003; dbg_wdata = 8'h33;
        waitAck(10, lat);
        checkOutput("t3_first_lat", 32'(lat), 32'(3));
        applyStimulus(1);
        checkOutput("t3_hold_pause", 32'(cpu_pause), 32'(1));
        checkOutput("t3_hold_busy", 32'(dbg_busy), 32'(0));
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0000;
        applyStimulus(1);
        checkOutput("t3_mem_oe_n1", 32'(mem_oe), 32'(1));
        applyStimulus(1);
        checkOutput("t3_ack_n2", 32'(dbg_ack), 32'(1));
        checkOutput("t3_rdata", 32'(dbg_rdata), 32'h8F);
        applyStimulus(1);
        checkOutput("t3_pause_held", 32'(cpu_pause), 32'(1));
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0002;
        waitAck(10, lat);
        checkOutput("t3_rd2_lat", 32'(lat), 32'(2));
        checkOutput("t3_rd2_data", 32'(dbg_rdata), 32'h25);
        applyStimulus(1);

        $display("[TB] directed: out-of-range read");
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h8000;
        applyStimulus(1);
        checkOutput("t4_no_we", 32'(mem_we), 32'(0));
        checkOutput("t4_no_oe", 32'(mem_oe), 32'(0));
        applyStimulus(1);
        checkOutput("t4_ack", 32'(dbg_ack), 32'(1));
        checkOutput("t4_err", 32'(dbg_err), 32'(1));
        checkOutput("t4_rdata_kept", 32'(dbg_rdata), 32'h25);
        dbg_hold = 1'b0;
        applyStimulus(1);
        checkOutput("t4_released", 32'(cpu_pause), 32'(0));

        $display("[TB] directed: drain timeout");
        cpu_idle = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0005; dbg_wdata = 8'h55;
        waitAck(40, lat);
        checkOutput("t5_latency", 32'(lat), 32'(DRAIN_TIMEOUT + 1));
        checkOutput("t5_err", 32'(dbg_err), 32'(1));
        applyStimulus(1);
        checkOutput("t5_released", 32'(cpu_pause), 32'(0));
        cpu_addr = 16'h0020; cpu_wdata = 8'h77; cpu_we = 1'b1;
        #1;
        checkOutput("t5_passthru", 32'(mem_we), 32'(1));
        applyStimulus(1);
        cpu_we = 1'b0;

        $display("[TB] directed: reset during drain");
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
        applyStimulus(2);
        checkOutput("t6_draining", 32'(dbg_busy), 32'(1));
        reset = 1'b1;
        #1;
        checkOutput("t6_pause_drop", 32'(cpu_pause), 32'(0));
        checkOutput("t6_busy_drop", 32'(dbg_busy), 32'(0));
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(2);
        checkOutput("t6_no_ack", 32'(dbg_ack), 32'(0));
        cpu_idle = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
        waitAck(10, lat);
        checkOutput("t6_later_lat", 32'(lat), 32'(3));
        checkOutput("t6_later_rdata", 32'(dbg_rdata), 32'h5A);
        applyStimulus(1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                reset = 1'b1;
                applyStimulus(1);
                reset = 1'b0;
            end
            cpu_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            s         = int'($urandom_range(0, 2));
            cpu_we    = (s == 1);
            cpu_oe    = (s == 2);
            cpu_wdata = 8'($urandom);
            cpu_idle  = ((i % 500) < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
            dbg_req   = ($urandom_range(0, 5) == 0);
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32768, 65535))
                                                    : 16'($urandom_range(0, 63));
            dbg_wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) dbg_hold = ~dbg_hold;
            applyStimulus(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
